// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the LCD write-bus receiver and its benches.
package lcd_spi_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {StIdle, StShift} rx_state_e;

  localparam logic [BYTE_W-1:0] CMD_NOP     = 8'h00;
  localparam logic [BYTE_W-1:0] CMD_SWRESET = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_SLPOUT  = 8'h11;
  localparam logic [BYTE_W-1:0] CMD_DISPON  = 8'h29;
  localparam logic [BYTE_W-1:0] CMD_RAMWR   = 8'h2C;
  localparam logic [BYTE_W-1:0] CMD_MADCTL  = 8'h36;
  localparam logic [BYTE_W-1:0] CMD_COLMOD  = 8'h3A;
  localparam logic [BYTE_W-1:0] FRMCTR1     = 8'hB1;
  localparam logic [BYTE_W-1:0] FRMCTR2     = 8'hB2;
  localparam logic [BYTE_W-1:0] FRMCTR3     = 8'hB3;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with a selectable reset value.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/lcd_spi_rx.sv
// Passive LCD write-bus receiver: oversampled SPI byte capture, command/param
// tracking and a single-entry valid/ready output register.
module lcd_spi_rx
  import lcd_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PIDX_W      = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LCD_SCL,
  input  logic              LCD_MOSI,
  input  logic              LCD_DC,
  input  logic              LCD_CS,
  input  logic              LCD_RSTN,
  output logic [BYTE_W-1:0] BYTE_DATA,
  output logic              BYTE_DC,
  output logic [BYTE_W-1:0] BYTE_CMD,
  output logic [PIDX_W-1:0] BYTE_PIDX,
  output logic              BYTE_VALID,
  input  logic              BYTE_READY,
  output logic              BUSY,
  output logic              LCD_RST_EVT,
  output logic              ERR_ABORT,
  output logic              ERR_OVF,
  input  logic              ERR_CLR
);

  localparam logic [PIDX_W-1:0] PIDX_ONE = PIDX_W'(1);
  localparam logic [PIDX_W-1:0] PIDX_MAX = '1;

  logic scl_s, mosi_s, dc_s, cs_s, rstn_s;

  // CS and RSTN reset to their inactive (high) level so reset gives BUSY=0 and no event.
  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (
    .CLK(CLK), .RST(RST), .d_i(LCD_SCL), .q_o(scl_s));
  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .CLK(CLK), .RST(RST), .d_i(LCD_MOSI), .q_o(mosi_s));
  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc (
    .CLK(CLK), .RST(RST), .d_i(LCD_DC), .q_o(dc_s));
  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .CLK(CLK), .RST(RST), .d_i(LCD_CS), .q_o(cs_s));
  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rstn (
    .CLK(CLK), .RST(RST), .d_i(LCD_RSTN), .q_o(rstn_s));

  rx_state_e         state_q;
  logic [2:0]        bit_cnt_q;
  logic [BYTE_W-1:0] shreg_q;
  logic              dc_q, done_q;
  logic              scl_prev_q, rstn_prev_q;
  logic [BYTE_W-1:0] cur_cmd_q;
  logic [PIDX_W-1:0] pidx_q;

  logic scl_rise, abort_set, accept, ovf_set;

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign abort_set = rstn_s && (state_q == StShift) && cs_s && (bit_cnt_q != 3'd0);
  assign accept    = BYTE_VALID & BYTE_READY;
  assign ovf_set   = done_q & BYTE_VALID & ~BYTE_READY;
  assign BUSY      = ~cs_s;

  // Receive FSM and shifter; done_q is a one-cycle byte-complete strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= '0;
      dc_q        <= 1'b0;
      done_q      <= 1'b0;
      scl_prev_q  <= 1'b0;
      rstn_prev_q <= 1'b1;
      LCD_RST_EVT <= 1'b0;
      ERR_ABORT   <= 1'b0;
    end else begin
      scl_prev_q  <= scl_s;
      rstn_prev_q <= rstn_s;
      LCD_RST_EVT <= rstn_prev_q & ~rstn_s;
      done_q      <= 1'b0;
      if (abort_set) begin
        ERR_ABORT <= 1'b1;
      end else if (ERR_CLR) begin
        ERR_ABORT <= 1'b0;
      end
      if (!rstn_s) begin
        state_q   <= StIdle;
        bit_cnt_q <= 3'd0;
      end else begin
        case (state_q)
          StIdle: begin
            if (!cs_s) begin
              state_q   <= StShift;
              bit_cnt_q <= 3'd0;
            end
          end
          StShift: begin
            if (cs_s) begin
              state_q   <= StIdle;
              bit_cnt_q <= 3'd0;
            end else if (scl_rise) begin
              shreg_q   <= {shreg_q[BYTE_W-2:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                dc_q   <= dc_s;
                done_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Command tracker and output holding register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_cmd_q  <= CMD_NOP;
      pidx_q     <= '0;
      BYTE_DATA  <= '0;
      BYTE_DC    <= 1'b0;
      BYTE_CMD   <= '0;
      BYTE_PIDX  <= '0;
      BYTE_VALID <= 1'b0;
      ERR_OVF    <= 1'b0;
    end else begin
      if (ovf_set) begin
        ERR_OVF <= 1'b1;
      end else if (ERR_CLR) begin
        ERR_OVF <= 1'b0;
      end
      if (accept) begin
        BYTE_VALID <= 1'b0;
      end
      if (done_q) begin
        if (!BYTE_VALID || accept) begin
          BYTE_VALID <= 1'b1;
          BYTE_DATA  <= shreg_q;
          BYTE_DC    <= dc_q;
          BYTE_CMD   <= dc_q ? cur_cmd_q : shreg_q;
          BYTE_PIDX  <= dc_q ? pidx_q : '0;
        end
        // Tracker advances even when the byte itself is dropped.
        if (!dc_q) begin
          cur_cmd_q <= shreg_q;
          pidx_q    <= '0;
        end else if (pidx_q != PIDX_MAX) begin
          pidx_q <= pidx_q + PIDX_ONE;
        end
      end
      if (!rstn_s) begin
        cur_cmd_q <= CMD_NOP;
        pidx_q    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Self-checking bench for lcd_spi_rx: vector table, corner sequences and a
// randomized run against a byte-level command/parameter model.
module tb_lcd_spi_rx;
  import lcd_spi_pkg::*;

  localparam int SYNC = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LCD_SCL = 1'b0, LCD_MOSI = 1'b0, LCD_DC = 1'b0, LCD_CS = 1'b1, LCD_RSTN = 1'b1;
  logic [7:0] BYTE_DATA, BYTE_CMD, BYTE_PIDX;
  logic       BYTE_DC, BYTE_VALID, BUSY, LCD_RST_EVT, ERR_ABORT, ERR_OVF;
  logic       BYTE_READY = 1'b1;
  logic       ERR_CLR = 1'b0;

  lcd_spi_rx #(.SYNC_STAGES(SYNC), .PIDX_W(8)) dut (
    .CLK(CLK), .RST(RST), .LCD_SCL(LCD_SCL), .LCD_MOSI(LCD_MOSI), .LCD_DC(LCD_DC),
    .LCD_CS(LCD_CS), .LCD_RSTN(LCD_RSTN), .BYTE_DATA(BYTE_DATA), .BYTE_DC(BYTE_DC),
    .BYTE_CMD(BYTE_CMD), .BYTE_PIDX(BYTE_PIDX), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .BUSY(BUSY), .LCD_RST_EVT(LCD_RST_EVT), .ERR_ABORT(ERR_ABORT),
    .ERR_OVF(ERR_OVF), .ERR_CLR(ERR_CLR));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
    logic [7:0] cmd;
    logic [7:0] pidx;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] cmd;
    logic [7:0] pidx;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  int   m_cmd, m_pidx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepted-byte collector plus hold-stability check while VALID & !READY.
  logic hold_prev = 1'b0;
  rec_t prev_rec;
  always @(negedge CLK) begin
    if (!RST) begin
      if (hold_prev) begin
        checks++;
        if (!BYTE_VALID || {BYTE_DATA, BYTE_DC, BYTE_CMD, BYTE_PIDX} != prev_rec) begin
          errors++;
          $display("FAIL hold_stable: got v=%b %h expected v=1 %h", BYTE_VALID,
                   {BYTE_DATA, BYTE_DC, BYTE_CMD, BYTE_PIDX}, prev_rec);
        end
      end
      if (BYTE_VALID && BYTE_READY) got_q.push_back({BYTE_DATA, BYTE_DC, BYTE_CMD, BYTE_PIDX});
    end
    hold_prev = !RST && BYTE_VALID && !BYTE_READY;
    prev_rec  = {BYTE_DATA, BYTE_DC, BYTE_CMD, BYTE_PIDX};
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cs_low();
    LCD_CS = 1'b0;
    ticks(2);
  endtask

  task automatic cs_high();
    LCD_SCL = 1'b0;
    ticks(2);
    LCD_CS = 1'b1;
    ticks(6);
  endtask

  // Sends the top n bits of b, MSB first.
  task automatic send_bits(input logic [7:0] b, input logic dc, input int n, input int hi,
                           input int lo);
    for (int i = 7; i > 7 - n; i--) begin
      LCD_MOSI = b[i];
      LCD_DC   = dc;
      LCD_SCL  = 1'b0;
      ticks(lo);
      LCD_SCL = 1'b1;
      ticks(hi);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    cs_low();
    send_bits(b, dc, 8, 2, 2);
    cs_high();
  endtask

  // Full byte whose 8th rise is timed: reports VALID rise latency and optionally
  // pulses READY for exactly one cycle at a chosen offset from that rise.
  task automatic probe(input logic [7:0] b, input logic dc, input int pulse_at, output int lat,
                       output bit drop);
    logic was;
    lat  = -1;
    drop = 1'b0;
    cs_low();
    send_bits(b, dc, 7, 2, 2);
    LCD_MOSI = b[0];
    LCD_DC   = dc;
    LCD_SCL  = 1'b0;
    ticks(2);
    was     = BYTE_VALID;
    LCD_SCL = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      if (j == pulse_at) BYTE_READY = 1'b1;
      tick();
      if (j == pulse_at) BYTE_READY = 1'b0;
      if (was && !BYTE_VALID) drop = 1'b1;
      if (lat < 0 && !was && BYTE_VALID) lat = j;
      if (j == 2) LCD_SCL = 1'b0;
    end
    cs_high();
  endtask

  task automatic lcd_reset_pulse();
    LCD_RSTN = 1'b0;
    ticks(4);
    LCD_RSTN = 1'b1;
    ticks(6);
  endtask

  task automatic model_push(input logic [7:0] b, input logic dc);
    if (!dc) begin
      m_cmd  = b;
      m_pidx = 0;
      exp_q.push_back({b, 1'b0, b, 8'h00});
    end else begin
      exp_q.push_back({b, 1'b1, 8'(m_cmd), 8'(m_pidx)});
      if (m_pidx < 255) m_pidx++;
    end
  endtask

  vec_t       tbl[7];
  int         lat, evt_cnt, nb, hi, lo, n;
  bit         drop;
  logic [7:0] rb;
  logic       rdc;

  initial begin
    tbl[0] = '{8'hB1, 1'b0, 8'hB1, 8'd0};
    tbl[1] = '{8'h05, 1'b1, 8'hB1, 8'd0};
    tbl[2] = '{8'h3C, 1'b1, 8'hB1, 8'd1};
    tbl[3] = '{8'h3C, 1'b1, 8'hB1, 8'd2};
    tbl[4] = '{8'h36, 1'b0, 8'h36, 8'd0};
    tbl[5] = '{8'hC8, 1'b1, 8'h36, 8'd0};
    tbl[6] = '{8'h2C, 1'b0, 8'h2C, 8'd0};

    ticks(3);
    RST = 1'b0;
    check("reset_outputs", {BYTE_DATA, BYTE_DC, BYTE_CMD, BYTE_PIDX, BYTE_VALID, BUSY,
                            LCD_RST_EVT, ERR_ABORT, ERR_OVF}, 30'd0);
    ticks(4);

    // FRMCTR1 sequence and follow-on commands, CS toggled per byte.
    for (int i = 0; i < 7; i++) begin
      got_q.delete();
      send_byte(tbl[i].data, tbl[i].dc);
      check($sformatf("tbl%0d_count", i), got_q.size(), 1);
      if (got_q.size() > 0)
        check($sformatf("tbl%0d_rec", i), got_q[0],
              {tbl[i].data, tbl[i].dc, tbl[i].cmd, tbl[i].pidx});
    end
    check("tbl_no_errors", {ERR_ABORT, ERR_OVF}, 2'b00);

    probe(8'hC3, 1'b1, 0, lat, drop);
    check("valid_latency", lat, SYNC + 2);

    // Abort after 5 bits.
    got_q.delete();
    cs_low();
    send_bits(8'hA5, 1'b0, 5, 2, 2);
    cs_high();
    check("abort_no_byte", got_q.size(), 0);
    check("abort_err", ERR_ABORT, 1'b1);
    send_byte(8'h2C, 1'b0);
    check("abort_next_count", got_q.size(), 1);
    if (got_q.size() > 0) check("abort_next_rec", got_q[0], {8'h2C, 1'b0, 8'h2C, 8'h00});
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("abort_clr", ERR_ABORT, 1'b0);

    // Overflow: second byte dropped while first is held.
    got_q.delete();
    BYTE_READY = 1'b0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("ovf_hold", {BYTE_VALID, BYTE_DATA}, {1'b1, 8'h11});
    check("ovf_err", ERR_OVF, 1'b1);
    check("ovf_none_out", got_q.size(), 0);
    BYTE_READY = 1'b1;
    ticks(6);
    check("ovf_drain_count", got_q.size(), 1);
    if (got_q.size() > 0) check("ovf_drain_data", got_q[0].data, 8'h11);
    check("ovf_valid_low", BYTE_VALID, 1'b0);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("ovf_clr", ERR_OVF, 1'b0);

    // Completion in the same cycle as an accept.
    got_q.delete();
    BYTE_READY = 1'b0;
    send_byte(8'h44, 1'b0);
    probe(8'h33, 1'b0, SYNC + 2, lat, drop);
    check("b2b_accepted", got_q.size(), 1);
    if (got_q.size() > 0) check("b2b_first", got_q[0].data, 8'h44);
    check("b2b_valid_cont", drop, 1'b0);
    check("b2b_loaded", {BYTE_VALID, BYTE_DATA}, {1'b1, 8'h33});
    check("b2b_no_ovf", ERR_OVF, 1'b0);
    BYTE_READY = 1'b1;
    ticks(4);
    check("b2b_second", got_q.size(), 2);

    // LCD reset mid-byte.
    send_byte(FRMCTR1, 1'b0);
    got_q.delete();
    cs_low();
    send_bits(8'hFF, 1'b1, 3, 2, 2);
    LCD_RSTN = 1'b0;
    evt_cnt  = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (LCD_RST_EVT) evt_cnt++;
    end
    check("lcdrst_evt_once", evt_cnt, 1);
    cs_high();
    LCD_RSTN = 1'b1;
    ticks(6);
    check("lcdrst_no_abort", ERR_ABORT, 1'b0);
    check("lcdrst_discard", got_q.size(), 0);
    send_byte(8'h05, 1'b1);
    check("lcdrst_next_count", got_q.size(), 1);
    if (got_q.size() > 0) check("lcdrst_next_rec", got_q[0], {8'h05, 1'b1, 8'h00, 8'h00});

    // RST mid-byte with a held byte and a sticky error outstanding.
    BYTE_READY = 1'b0;
    send_byte(8'h5A, 1'b1);
    send_byte(8'h5B, 1'b1);
    cs_low();
    send_bits(8'hF0, 1'b1, 4, 2, 2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_mid_outputs", {BYTE_DATA, BYTE_DC, BYTE_CMD, BYTE_PIDX, BYTE_VALID, BUSY,
                              LCD_RST_EVT, ERR_ABORT, ERR_OVF}, 30'd0);
    BYTE_READY = 1'b1;
    got_q.delete();
    cs_high();
    send_byte(CMD_MADCTL, 1'b0);
    send_byte(8'hA0, 1'b1);
    check("rst_next_count", got_q.size(), 2);
    if (got_q.size() > 1) begin
      check("rst_next_cmd", got_q[0], {8'h36, 1'b0, 8'h36, 8'h00});
      check("rst_next_par", got_q[1], {8'hA0, 1'b1, 8'h36, 8'h00});
    end

    // Randomized windows against the model, including one long burst to saturate pidx.
    lcd_reset_pulse();
    m_cmd  = 0;
    m_pidx = 0;
    got_q.delete();
    exp_q.delete();
    for (int w = 0; w < 30; w++) begin
      if (w == 10) begin
        nb = 260;
        hi = 2;
        lo = 2;
      end else begin
        nb = $urandom_range(1, 4);
        hi = $urandom_range(2, 4);
        lo = $urandom_range(2, 4);
      end
      if ($urandom_range(0, 7) == 0) begin
        lcd_reset_pulse();
        m_cmd  = 0;
        m_pidx = 0;
      end
      cs_low();
      for (int k = 0; k < nb; k++) begin
        rb = 8'($urandom);
        if (w == 10) rdc = (k != 0);
        else rdc = ($urandom_range(0, 3) != 0);
        send_bits(rb, rdc, 8, hi, lo);
        model_push(rb, rdc);
      end
      cs_high();
    end
    check("rand_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("rand_rec%0d", i), got_q[i], exp_q[i]);
    check("rand_no_errors", {ERR_ABORT, ERR_OVF}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_spi_rx.md
Name: lcd_spi_rx

Overview:
Passive receiver/decoder for the 4-wire LCD write bus (SCL, MOSI, DC, CS, active-low LCD reset) that the LCD init and frame-control sequencers drive. It oversamples the bus on the system clock, reassembles MSB-first bytes and tags each byte as command (DC=0) or parameter (DC=1). It also tracks the current command and parameter index, and presents decoded bytes on a valid/ready interface. It is used for on-board wave decode/loopback and as the bench-side checker for every LCD sequencer block.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer (min 2)
PIDX_W, 8, width of parameter index counter

Ports:
CLK  in  1  system clock; the only clock
RST  in  1  synchronous, active-high reset
LCD_SCL  in  1  bus serial clock (async to CLK)
LCD_MOSI  in  1  bus serial data, MSB first
LCD_DC  in  1  0=command byte, 1=parameter byte
LCD_CS  in  1  active-low chip select
LCD_RSTN  in  1  active-low LCD hardware reset line
BYTE_DATA  out  8  received byte
BYTE_DC  out  1  DC value captured with byte
BYTE_CMD  out  8  command this byte belongs to (itself if BYTE_DC=0)
BYTE_PIDX  out  PIDX_W  parameter index (0 for command byte and for first parameter)
BYTE_VALID  out  1  output holding register full
BYTE_READY  in  1  consumer accepts when VALID&READY
BUSY  out  1  synchronized CS low
LCD_RST_EVT  out  1  one-cycle pulse on synchronized LCD_RSTN falling edge
ERR_ABORT  out  1  sticky: CS rose mid-byte
ERR_OVF  out  1  sticky: byte dropped because output register was full
ERR_CLR  in  1  clears both sticky errors

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous and active-high. Reset drives all outputs to 0, state to IDLE, bit_cnt to 0, cur_cmd to 0x00 and pidx to 0.
- Synchronization: all five LCD inputs pass through SYNC_STAGES-flop synchronizers (equal depth, so relative alignment is preserved). An SCL rising edge is detected from the synchronized value and its previous-cycle copy. Legal input: SCL high and low phases each last at least 2 CLK cycles, and MOSI/DC are stable at least 1 cycle either side of the SCL rise.
- FSM states:
  - IDLE: sync CS high; SCL edges ignored. Goes to SHIFT when sync CS=0, with bit_cnt=0.
  - SHIFT: on each SCL rise, shift MOSI into shreg[0] (shreg shifts left) and increment bit_cnt.
    - On the 8th rise, DC is captured from the same sample, the byte completes and bit_cnt wraps to 0. The FSM stays in SHIFT, so multiple bytes per CS-low window are legal.
    - Sync CS=1 with bit_cnt=0 goes to IDLE, no error.
    - Sync CS=1 with bit_cnt 1..7 discards the partial byte, sets ERR_ABORT and goes to IDLE.
- Byte completion updates the tracker:
  - DC=0: cur_cmd = byte, pidx = 0; emitted BYTE_CMD = byte, BYTE_PIDX = 0.
  - DC=1: emitted BYTE_CMD = cur_cmd, BYTE_PIDX = pidx; then pidx increments, saturating at all-ones.
  - The tracker updates even if the byte is dropped.
- Latency: BYTE_VALID rises SYNC_STAGES+2 CLK cycles after the 8th SCL rise at the pins.
- Handshake:
  - VALID stays high with all BYTE_* fields stable until a cycle where VALID&READY is true.
  - Completion while VALID=1 and READY=0: the new byte is dropped, the register is unchanged and ERR_OVF is set.
  - Completion in the same cycle as an accept: the new byte loads and VALID stays 1, with no error.
- LCD_RSTN sync low:
  - Forces IDLE, bit_cnt=0, cur_cmd=0x00 and pidx=0.
  - No ERR_ABORT is raised.
  - The output register is not flushed.
  - LCD_RST_EVT pulses once per falling edge.
- Errors:
  - ERR_CLR clears both sticky errors.
  - If a set event and ERR_CLR occur in the same cycle, set wins.
- BUSY equals the synchronized inverse of LCD_CS.

Decomposition:
- Package lcd_spi_pkg contains:
  - rx state enum (IDLE, SHIFT)
  - BYTE_W=8
  - CMD_NOP=8'h00 (tracker reset value)
  - common ST7735 opcodes, e.g. FRMCTR1=8'hB1, used by benches
- Sub-module sync_bit: an N-stage single-bit synchronizer with a SYNC_STAGES parameter, instantiated once per LCD input.
- FSM, shifter, tracker and output register stay in lcd_spi_rx.

Test Plan:
- FRMCTR sequence: send B1 (DC=0), 05, 3C, 3C (DC=1), CS toggled per byte, SCL = CLK/4, READY=1. Expect four VALIDs with (data, dc, cmd, pidx) = (B1,0,B1,0), (05,1,B1,0), (3C,1,B1,1), (3C,1,B1,2), and no errors.
- Abort: CS rises after 5 bits of 0xA5. Expect no VALID and ERR_ABORT=1. A following full byte 0x2C (DC=0) is then received correctly; ERR_CLR returns ERR_ABORT to 0.
- Overflow: READY=0 while sending 0x11 then 0x22. Expect the register to hold 0x11 and ERR_OVF=1. With READY=1, 0x11 is accepted; 0x22 is never output.
- Back-to-back accept: READY pulses in the exact cycle 0x33 completes while 0x44 is held. Expect 0x44 accepted, 0x33 loaded, VALID continuous high, and ERR_OVF=0.
- LCD reset mid-byte: LCD_RSTN goes low after 3 bits. Expect LCD_RST_EVT as a single pulse, no ERR_ABORT, and the partial byte discarded. The next parameter byte 0x05 reports cmd=0x00 and pidx=0.
- RST mid-byte, asserted 1 cycle: expect all outputs 0 and state IDLE. A subsequent command 0x36 decodes normally.
